// File: rtl/kabeta_pkg.sv
// Shared Kabeta fetch definitions: no-op encoding, vector defaults, FSM states.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package kabeta_pkg;

   // ADD(R31, R31, R31): architecturally a no-op, fed to decode for bubbles
   localparam logic [31:0] I_NOP = 32'h83FF_F800;

   localparam logic [31:0] RESET_VECTOR_DEF = 32'h8000_0000;
   localparam logic [31:0] ILLOP_VECTOR_DEF = 32'h8000_0004;
   localparam logic [31:0] XADDR_VECTOR_DEF = 32'h8000_0008;

   typedef enum logic [1:0] {
      ST_RESET = 2'd0,
      ST_RUN   = 2'd1,
      ST_KILL  = 2'd2
   } fetch_state_t;

   // Sequential successor: the low 31 bits wrap, the supervisor bit never changes
   function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
      return {pc[31], pc[30:0] + 31'd4};
   endfunction

endpackage

// File: rtl/fetch_next_pc.sv
// Next-PC priority mux: illop > interrupt (user mode only) > jump > branch > sequential.
// Latency: purely combinational.
// Backpressure: none here; the caller only applies next_pc on unstalled cycles.
module fetch_next_pc
   import kabeta_pkg::*;
#(
   parameter logic [31:0] ILLOP_VECTOR = ILLOP_VECTOR_DEF,
   parameter logic [31:0] XADDR_VECTOR = XADDR_VECTOR_DEF
) (
   input  logic [31:0] pc,
   input  logic        ill_op,
   input  logic        int_req,
   input  logic        jump_taken,
   input  logic [31:0] jump_target,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   output logic [31:0] next_pc,
   output logic        redirect,
   output logic        int_sel
);

   // Target low bits are forced to word alignment; a branch cannot change mode
   logic unused_bits;
   assign unused_bits = ^{jump_target[1:0], branch_target[31], branch_target[1:0]};

   // Priority selection of the next program counter
   always_comb begin
      next_pc  = pc_plus4(pc);
      redirect = 1'b0;
      int_sel  = 1'b0;
      if (ill_op) begin
         next_pc  = ILLOP_VECTOR;
         redirect = 1'b1;
      end else if (int_req && !pc[31]) begin
         // interrupts are masked while in supervisor mode
         next_pc  = XADDR_VECTOR;
         redirect = 1'b1;
         int_sel  = 1'b1;
      end else if (jump_taken) begin
         // JMP may drop to user mode but can never gain supervisor rights
         next_pc  = {pc[31] & jump_target[31], jump_target[30:2], 2'b00};
         redirect = 1'b1;
      end else if (branch_taken) begin
         next_pc  = {pc[31], branch_target[30:2], 2'b00};
         redirect = 1'b1;
      end
   end

endmodule

// File: rtl/instruction_fetch.sv
// Kabeta fetch stage: owns the PC, drives the I-port, pairs words with PC+4, kills wrong-path words.
// Latency: one cycle from Addr_I to Instr_ID; a redirect or Flush costs exactly one bubble.
// Backpressure: Stall freezes PC, FSM and *_ID outputs and drops En_I. Optional FETCH_STAT_EN adds counters.
module instruction_fetch
   import kabeta_pkg::*;
#(
   parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEF,
   parameter logic [31:0] ILLOP_VECTOR = ILLOP_VECTOR_DEF,
   parameter logic [31:0] XADDR_VECTOR = XADDR_VECTOR_DEF
) (
   input  logic        Clock,
   input  logic        SysReset,
   input  logic        Stall,
   input  logic        Flush,
   input  logic        BranchTaken,
   input  logic [31:0] BranchTarget,
   input  logic        JumpTaken,
   input  logic [31:0] JumpTarget,
   input  logic        IllOp,
   input  logic        IntReq,
   output logic        En_I,
   output logic [28:0] Addr_I,
   input  logic [31:0] Data_I,
   output logic [31:0] Instr_ID,
   output logic [31:0] PC_ID,
   output logic        Valid_ID,
   output logic        IntTaken_ID
`ifdef FETCH_STAT_EN
   ,
   output logic [31:0] FetchCount,
   output logic [31:0] BubbleCount
`endif
);

   fetch_state_t state;
   logic [31:0]  pc;
   logic [31:0]  pc_id_q;
   logic         valid_q;
   logic         int_taken_q;
   logic         int_pend;     // next surviving word is the interrupt entry

   logic [31:0]  next_pc;
   logic         redirect;
   logic         int_sel;
   logic         kill;
   logic         fetching;

   fetch_next_pc #(
      .ILLOP_VECTOR (ILLOP_VECTOR),
      .XADDR_VECTOR (XADDR_VECTOR)
   ) u_next_pc (
      .pc            (pc),
      .ill_op        (IllOp),
      .int_req       (IntReq),
      .jump_taken    (JumpTaken),
      .jump_target   (JumpTarget),
      .branch_taken  (BranchTaken),
      .branch_target (BranchTarget),
      .next_pc       (next_pc),
      .redirect      (redirect),
      .int_sel       (int_sel)
   );

   // The word fetched this cycle is wrong-path whenever the PC is redirected or decode flushes
   assign kill     = redirect || Flush;
   assign fetching = (state != ST_RESET) && !Stall;

   assign En_I        = fetching;
   assign Addr_I      = pc[30:2];
   // Memory holds its q while stalled, so Data_I stays paired with the held PC_ID
   assign Instr_ID    = valid_q ? Data_I : I_NOP;
   assign PC_ID       = pc_id_q;
   assign Valid_ID    = valid_q;
   assign IntTaken_ID = int_taken_q;

   // Fetch FSM with registered decode-side outputs
   always_ff @(posedge Clock) begin
      if (!SysReset) begin
         state       <= ST_RESET;
         pc          <= RESET_VECTOR;
         pc_id_q     <= '0;
         valid_q     <= 1'b0;
         int_taken_q <= 1'b0;
         int_pend    <= 1'b0;
      end else begin
         case (state)
            ST_RESET: begin
               // first cycle out of reset only arms the fetch
               state <= ST_RUN;
            end
            default: begin
               if (Stall) begin
                  // a flush still kills the presented word, everything else holds
                  if (Flush) begin
                     valid_q     <= 1'b0;
                     int_taken_q <= 1'b0;
                  end
               end else begin
                  pc          <= next_pc;
                  pc_id_q     <= pc_plus4(pc);
                  valid_q     <= !kill;
                  int_taken_q <= !kill && int_pend;
                  if (redirect) begin
                     int_pend <= int_sel;
                  end else if (!kill) begin
                     int_pend <= 1'b0;
                  end
                  state <= kill ? ST_KILL : ST_RUN;
               end
            end
         endcase
      end
   end

`ifdef FETCH_STAT_EN
   logic [31:0] fetch_cnt;
   logic [31:0] bubble_cnt;

   // Count words consumed by decode and cycles spent in the kill bubble
   always_ff @(posedge Clock) begin
      if (!SysReset) begin
         fetch_cnt  <= '0;
         bubble_cnt <= '0;
      end else begin
         if (valid_q && !Stall) begin
            fetch_cnt <= fetch_cnt + 32'd1;
         end
         if (state == ST_KILL) begin
            bubble_cnt <= bubble_cnt + 32'd1;
         end
      end
   end

   assign FetchCount  = fetch_cnt;
   assign BubbleCount = bubble_cnt;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed vector table, then random stimulus vs a reference model.
// Latency: memory stub returns the addressed word one cycle after En_I.
// Backpressure: Stall is driven directly; the stub holds its output when En_I is low.
module tb_instruction_fetch;
   import kabeta_pkg::*;

   logic        Clock = 1'b0;
   logic        SysReset, Stall, Flush, BranchTaken, JumpTaken, IllOp, IntReq;
   logic [31:0] BranchTarget, JumpTarget, Data_I, Instr_ID, PC_ID;
   logic        En_I, Valid_ID, IntTaken_ID;
   logic [28:0] Addr_I;
`ifdef FETCH_STAT_EN
   logic [31:0] FetchCount, BubbleCount;
`endif

   int checks = 0;
   int failures = 0;

   always #5 Clock = ~Clock;

   instruction_fetch dut (
      .Clock        (Clock),
      .SysReset     (SysReset),
      .Stall        (Stall),
      .Flush        (Flush),
      .BranchTaken  (BranchTaken),
      .BranchTarget (BranchTarget),
      .JumpTaken    (JumpTaken),
      .JumpTarget   (JumpTarget),
      .IllOp        (IllOp),
      .IntReq       (IntReq),
      .En_I         (En_I),
      .Addr_I       (Addr_I),
      .Data_I       (Data_I),
      .Instr_ID     (Instr_ID),
      .PC_ID        (PC_ID),
      .Valid_ID     (Valid_ID),
      .IntTaken_ID  (IntTaken_ID)
`ifdef FETCH_STAT_EN
      ,
      .FetchCount   (FetchCount),
      .BubbleCount  (BubbleCount)
`endif
   );

   // ---------------- instruction memory stub ----------------
   logic [31:0] mem [0:1023];

   function automatic logic [31:0] memword(input logic [9:0] idx);
      return 32'hC0D0_0000 | {22'd0, idx};
   endfunction

   always @(posedge Clock) begin
      if (En_I) Data_I <= mem[Addr_I[9:0]];
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   // ---------------- reference model ----------------
   // Tracks the architectural PC, the word presented to decode and whether it survived.
   logic        m_ok = 1'b0;
   logic        m_started, m_valid, m_int, m_pend, m_pcid_known, m_inkill;
   logic [31:0] m_pc, m_pres, m_pcid, m_fc, m_bc;

   task automatic model_edge();
      logic [31:0] tgt;
      logic        redir, isint;
      if (!SysReset) begin
         m_ok = 1'b1; m_started = 1'b0; m_valid = 1'b0; m_int = 1'b0; m_pend = 1'b0;
         m_pc = 32'h8000_0000; m_pres = '0; m_pcid = '0; m_pcid_known = 1'b1;
         m_inkill = 1'b0; m_fc = '0; m_bc = '0;
      end else if (!m_started) begin
         m_started = 1'b1;
      end else begin
         if (m_valid && !Stall) m_fc = m_fc + 1;
         if (m_inkill) m_bc = m_bc + 1;
         if (Stall) begin
            if (Flush) begin m_valid = 1'b0; m_int = 1'b0; end
         end else begin
            redir = 1'b1; isint = 1'b0;
            if (IllOp) tgt = 32'h8000_0004;
            else if (IntReq && m_pc < 32'h8000_0000) begin tgt = 32'h8000_0008; isint = 1'b1; end
            else if (JumpTaken) tgt = (JumpTarget & 32'h7FFF_FFFC) | (JumpTarget & m_pc & 32'h8000_0000);
            else if (BranchTaken) tgt = (BranchTarget & 32'h7FFF_FFFC) | (m_pc & 32'h8000_0000);
            else begin tgt = (m_pc & 32'h8000_0000) | ((m_pc + 4) & 32'h7FFF_FFFF); redir = 1'b0; end
            m_valid = !(redir || Flush);
            m_pres = m_pc;
            m_pcid = (m_pc & 32'h8000_0000) | ((m_pc + 4) & 32'h7FFF_FFFF);
            m_pcid_known = m_valid;
            m_int = m_valid && m_pend;
            if (m_valid) m_pend = 1'b0;
            if (redir) m_pend = isint;
            m_inkill = redir || Flush;
            m_pc = tgt;
         end
      end
   endtask

   task automatic model_check();
      chk("m_en", {31'd0, En_I}, {31'd0, m_started && !Stall});
      chk("m_addr", {3'd0, Addr_I}, {3'd0, m_pc[30:2]});
      chk("m_valid", {31'd0, Valid_ID}, {31'd0, m_valid});
      chk("m_instr", Instr_ID, m_valid ? memword(m_pres[11:2]) : I_NOP);
      chk("m_int", {31'd0, IntTaken_ID}, {31'd0, m_int});
      if (m_pcid_known) chk("m_pcid", PC_ID, m_pcid);
`ifdef FETCH_STAT_EN
      chk("m_fetchcnt", FetchCount, m_fc);
      chk("m_bubblecnt", BubbleCount, m_bc);
`endif
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      logic        rst, stall, flush, br, jmp, ill, irq;
      logic [31:0] bt, jt;
      logic        v;
      logic [9:0]  idx;
      logic [31:0] pcid;
      logic        chk_pc;
      logic [28:0] addr;
      logic        en, it;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input logic rst, stall, flush, br, input logic [31:0] bt,
                      input logic jmp, input logic [31:0] jt, input logic ill, irq,
                      input logic v, input logic [9:0] idx, input logic [31:0] pcid,
                      input logic chk_pc, input logic [28:0] addr, input logic en, it);
      vec_t r;
      r.rst = rst; r.stall = stall; r.flush = flush; r.br = br; r.bt = bt; r.jmp = jmp;
      r.jt = jt; r.ill = ill; r.irq = irq; r.v = v; r.idx = idx; r.pcid = pcid;
      r.chk_pc = chk_pc; r.addr = addr; r.en = en; r.it = it;
      tbl.push_back(r);
   endtask

   task automatic row_check(input int i);
      vec_t r;
      r = tbl[i];
      chk($sformatf("row%0d_valid", i), {31'd0, Valid_ID}, {31'd0, r.v});
      chk($sformatf("row%0d_instr", i), Instr_ID, r.v ? memword(r.idx) : I_NOP);
      chk($sformatf("row%0d_addr", i), {3'd0, Addr_I}, {3'd0, r.addr});
      chk($sformatf("row%0d_en", i), {31'd0, En_I}, {31'd0, r.en});
      chk($sformatf("row%0d_int", i), {31'd0, IntTaken_ID}, {31'd0, r.it});
      if (r.chk_pc) chk($sformatf("row%0d_pcid", i), PC_ID, r.pcid);
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = memword(i[9:0]);
      SysReset = 1'b0; Stall = 1'b0; Flush = 1'b0; BranchTaken = 1'b0; JumpTaken = 1'b0;
      IllOp = 1'b0; IntReq = 1'b0; BranchTarget = '0; JumpTarget = '0;

      //  rst st fl br bt            jmp jt            il iq   v  idx      pcid          cp addr         en it
      add(0, 0, 0, 0, 32'h0,        0, 32'h0,        0, 0,   0, 10'h0,   32'h0,         1, 29'h0,       0, 0); // reset
      add(1, 0, 0, 0, 32'h0,        0, 32'h0,        0, 0,   0, 10'h0,   32'h0,         1, 29'h0,       1, 0); // release
      add(1, 0, 0, 0, 32'h0,        0, 32'h0,        0, 0,   1, 10'h0,   32'h8000_0004, 1, 29'h1,       1, 0); // A
      add(1, 0, 0, 0, 32'h0,        0, 32'h0,        0, 0,   1, 10'h1,   32'h8000_0008, 1, 29'h2,       1, 0); // B
      add(1, 0, 0, 0, 32'h0,        0, 32'h0,        0, 0,   1, 10'h2,   32'h8000_000C, 1, 29'h3,       1, 0); // C
      add(1, 0, 0, 1, 32'h100,      0, 32'h0,        0, 0,   0, 10'h0,   32'h0,         0, 29'h40,      1, 0); // branch
      add(1, 0, 0, 0, 32'h0,        0, 32'h0,        0, 0,   1, 10'h40,  32'h8000_0104, 1, 29'h41,      1, 0);
      add(1, 0, 0, 0, 32'h0,        1, 32'h200,      0, 0,   0, 10'h0,   32'h0,         0, 29'h80,      1, 0); // jump drops mode
      add(1, 0, 0, 0, 32'h0,        0, 32'h0,        0, 0,   1, 10'h80,  32'h0000_0204, 1, 29'h81,      1, 0);
      add(1, 0, 0, 0, 32'h0,        1, 32'h8000_0300,0, 0,   0, 10'h0,   32'h0,         0, 29'hC0,      1, 0); // user jump
      add(1, 0, 0, 0, 32'h0,        0, 32'h0,        0, 1,   0, 10'h0,   32'h0,         0, 29'h2,       1, 0); // irq in KILL
      add(1, 0, 0, 0, 32'h0,        0, 32'h0,        0, 1,   1, 10'h2,   32'h8000_000C, 1, 29'h3,       1, 1); // entry word
      add(1, 0, 0, 0, 32'h0,        0, 32'h0,        0, 1,   1, 10'h3,   32'h8000_0010, 1, 29'h4,       1, 0); // irq masked
      add(1, 1, 0, 0, 32'h0,        0, 32'h0,        0, 0,   1, 10'h3,   32'h8000_0010, 1, 29'h4,       0, 0); // stall x3
      add(1, 1, 0, 1, 32'h100,      0, 32'h0,        0, 0,   1, 10'h3,   32'h8000_0010, 1, 29'h4,       0, 0);
      add(1, 1, 0, 0, 32'h0,        1, 32'h200,      1, 0,   1, 10'h3,   32'h8000_0010, 1, 29'h4,       0, 0);
      add(1, 0, 0, 0, 32'h0,        0, 32'h0,        0, 0,   1, 10'h4,   32'h8000_0014, 1, 29'h5,       1, 0); // resume
      add(1, 0, 0, 0, 32'h0,        1, 32'h200,      1, 0,   0, 10'h0,   32'h0,         0, 29'h1,       1, 0); // illop wins
      add(1, 0, 0, 0, 32'h0,        0, 32'h0,        0, 0,   1, 10'h1,   32'h8000_0008, 1, 29'h2,       1, 0);
      add(1, 1, 1, 0, 32'h0,        0, 32'h0,        0, 0,   0, 10'h0,   32'h8000_0008, 1, 29'h2,       0, 0); // flush+stall
      add(1, 0, 0, 0, 32'h0,        0, 32'h0,        0, 0,   1, 10'h2,   32'h8000_000C, 1, 29'h3,       1, 0);
      add(1, 0, 1, 0, 32'h0,        0, 32'h0,        0, 0,   0, 10'h0,   32'h0,         0, 29'h4,       1, 0); // flush
      add(1, 1, 0, 0, 32'h0,        0, 32'h0,        0, 0,   0, 10'h0,   32'h0,         0, 29'h4,       0, 0); // stall in KILL
      add(0, 1, 0, 1, 32'h100,      0, 32'h0,        0, 0,   0, 10'h0,   32'h0,         1, 29'h0,       0, 0); // reset wins
      add(1, 0, 0, 0, 32'h0,        0, 32'h0,        0, 0,   0, 10'h0,   32'h0,         1, 29'h0,       1, 0);
      add(1, 0, 0, 0, 32'h0,        0, 32'h0,        0, 0,   1, 10'h0,   32'h8000_0004, 1, 29'h1,       1, 0);
      add(1, 0, 0, 1, 32'h7FFF_FFFC,0, 32'h0,        0, 0,   0, 10'h0,   32'h0,         0, 29'h1FFFFFFF,1, 0); // to top
      add(1, 0, 0, 0, 32'h0,        0, 32'h0,        0, 0,   1, 10'h3FF, 32'h8000_0000, 1, 29'h0,       1, 0); // wrap
      add(1, 0, 0, 0, 32'h0,        0, 32'h0,        0, 0,   1, 10'h0,   32'h8000_0004, 1, 29'h1,       1, 0);

      for (int i = 0; i < tbl.size(); i++) begin
         @(negedge Clock);
         SysReset = tbl[i].rst; Stall = tbl[i].stall; Flush = tbl[i].flush;
         BranchTaken = tbl[i].br; BranchTarget = tbl[i].bt;
         JumpTaken = tbl[i].jmp; JumpTarget = tbl[i].jt;
         IllOp = tbl[i].ill; IntReq = tbl[i].irq;
         #1;
         if (m_ok) model_check();
         @(posedge Clock);
         model_edge();
         #1;
         row_check(i);
      end

      // randomized traffic against the reference model
      for (int n = 0; n < 3000; n++) begin
         @(negedge Clock);
         SysReset     = ($urandom_range(0, 99) != 0);
         Stall        = ($urandom_range(0, 3) == 0);
         Flush        = ($urandom_range(0, 11) == 0);
         BranchTaken  = ($urandom_range(0, 9) == 0);
         JumpTaken    = ($urandom_range(0, 11) == 0);
         IllOp        = ($urandom_range(0, 29) == 0);
         IntReq       = ($urandom_range(0, 7) == 0);
         BranchTarget = $urandom;
         JumpTarget   = $urandom;
         #1;
         if (m_ok) model_check();
         @(posedge Clock);
         model_edge();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
